// File: rtl/rename_regfile_if.sv
// Decoder/ROB-facing bus of the rename register file: rename, commit,
// misbranch flush and the two source-operand read ports.
interface rename_regfile_if #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4
);
   localparam int IDX_W = $clog2(REG_NUM);

   logic [IDX_W-1:0]  in_rename_reg;
   logic [TAG_W-1:0]  in_rename_tag;
   logic [IDX_W-1:0]  in_commit_reg;
   logic [TAG_W-1:0]  in_commit_rob_tag;
   logic [DATA_W-1:0] in_commit_value;
   logic              in_misbranch;
   logic [IDX_W-1:0]  in_rs1;
   logic [IDX_W-1:0]  in_rs2;
   logic [DATA_W-1:0] out_value1;
   logic [DATA_W-1:0] out_value2;
   logic [TAG_W-1:0]  out_tag1;
   logic [TAG_W-1:0]  out_tag2;
   logic [5:0]        out_pending_cnt;

   modport master (
      output in_rename_reg, in_rename_tag, in_commit_reg, in_commit_rob_tag,
             in_commit_value, in_misbranch, in_rs1, in_rs2,
      input  out_value1, out_value2, out_tag1, out_tag2, out_pending_cnt
   );

   modport slave (
      input  in_rename_reg, in_rename_tag, in_commit_reg, in_commit_rob_tag,
             in_commit_value, in_misbranch, in_rs1, in_rs2,
      output out_value1, out_value2, out_tag1, out_tag2, out_pending_cnt
   );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags for the OoO core.
// Define REGFILE_BYPASS_EN to forward a same-cycle matching commit to the read ports.
module rename_regfile #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4
) (
   input logic            clk,
   input logic            rst,
   rename_regfile_if.slave bus
);
   localparam int IDX_W = $clog2(REG_NUM);

   logic [DATA_W-1:0] value_q [REG_NUM];
   logic [TAG_W-1:0]  tag_q   [REG_NUM];
   logic [TAG_W-1:0]  tag_d   [REG_NUM];
   logic [5:0]        cnt_q;
   logic [5:0]        cnt_d;
   logic              rename_en;
   logic              commit_en;

   // A flush drops any rename issued alongside it, but never the commit.
   assign rename_en = (bus.in_rename_reg != '0) && (bus.in_rename_tag != '0) && !bus.in_misbranch;
   assign commit_en = (bus.in_commit_reg != '0);

   // Rename overrides a same-cycle commit so a younger producer is never lost.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         tag_d[i] = tag_q[i];
         if (bus.in_misbranch) begin
            tag_d[i] = '0;
         end else begin
            if (commit_en && (IDX_W'(i) == bus.in_commit_reg) && (tag_q[i] == bus.in_commit_rob_tag))
               tag_d[i] = '0;
            if (rename_en && (IDX_W'(i) == bus.in_rename_reg))
               tag_d[i] = bus.in_rename_tag;
         end
         if (tag_d[i] != '0)
            cnt_d = cnt_d + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++)
            tag_q[i] <= tag_d[i];
         if (commit_en)
            value_q[bus.in_commit_reg] <= bus.in_commit_value;
         cnt_q <= cnt_d;
      end
   end

   function automatic logic [TAG_W+DATA_W-1:0] lookup(input logic [IDX_W-1:0] rs);
      logic [TAG_W+DATA_W-1:0] r;
      r = {tag_q[rs], value_q[rs]};
      if (rs == '0)
         r = '0;
`ifdef REGFILE_BYPASS_EN
      else if (commit_en && (rs == bus.in_commit_reg) && (tag_q[rs] == bus.in_commit_rob_tag))
         r = {{TAG_W{1'b0}}, bus.in_commit_value};
`else
      else
         r = {tag_q[rs], value_q[rs]};
`endif
      return r;
   endfunction

   assign {bus.out_tag1, bus.out_value1} = lookup(bus.in_rs1);
   assign {bus.out_tag2, bus.out_value2} = lookup(bus.in_rs2);
   assign bus.out_pending_cnt = cnt_q;
endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed vectors, corner sequences
// and randomized traffic against an array-based reference model.
module tb_rename_regfile;
   logic clk;
   logic rst;
   int   check_count = 0;
   int   pass_count  = 0;

   rename_regfile_if #(.REG_NUM(32), .DATA_W(32), .TAG_W(4)) bus ();

   rename_regfile #(.REG_NUM(32), .DATA_W(32), .TAG_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: what every architectural register holds and who produces it.
   logic [31:0] m_val [32];
   logic [3:0]  m_tag [32];

   typedef struct {
      logic [4:0]  rr;
      logic [3:0]  rt;
      logic [4:0]  cr;
      logic [3:0]  ct;
      logic [31:0] cv;
      logic        mb;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] ev1;
      logic [3:0]  et1;
      logic [31:0] ev2;
      logic [3:0]  et2;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t vecs [14];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0;
         m_tag[i] = '0;
      end
   endtask

   // Applies the spec rules for the inputs currently on the bus.
   task automatic model_edge();
      logic clr;
      clr = 1'b0;
      if (bus.in_commit_reg != 0) begin
         clr = (m_tag[bus.in_commit_reg] == bus.in_commit_rob_tag);
         m_val[bus.in_commit_reg] = bus.in_commit_value;
      end
      if (bus.in_misbranch) begin
         for (int i = 0; i < 32; i++) m_tag[i] = '0;
      end else begin
         if (clr) m_tag[bus.in_commit_reg] = '0;
         if (bus.in_rename_reg != 0 && bus.in_rename_tag != 0)
            m_tag[bus.in_rename_reg] = bus.in_rename_tag;
      end
   endtask

   task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output logic [3:0] t);
      v = m_val[rs];
      t = m_tag[rs];
      if (rs == 0) begin
         v = '0;
         t = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (bus.in_commit_reg != 0 && bus.in_commit_reg == rs && m_tag[rs] == bus.in_commit_rob_tag) begin
         v = bus.in_commit_value;
         t = '0;
      end
`endif
   endtask

   function automatic logic [5:0] model_count();
      logic [5:0] n;
      n = '0;
      for (int i = 1; i < 32; i++)
         if (m_tag[i] != 0) n = n + 6'd1;
      return n;
   endfunction

   task automatic applyStimulus(input logic [4:0] rr, input logic [3:0] rt, input logic [4:0] cr,
                                input logic [3:0] ct, input logic [31:0] cv, input logic mb,
                                input logic [4:0] rs1, input logic [4:0] rs2);
      bus.in_rename_reg     = rr;
      bus.in_rename_tag     = rt;
      bus.in_commit_reg     = cr;
      bus.in_commit_rob_tag = ct;
      bus.in_commit_value   = cv;
      bus.in_misbranch      = mb;
      bus.in_rs1            = rs1;
      bus.in_rs2            = rs2;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s got %h expected %h", name, act, exp);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] ev1, input logic [3:0] et1,
                              input logic [31:0] ev2, input logic [3:0] et2, input logic [5:0] ecnt);
      check_val({name, ".value1"}, bus.out_value1, ev1);
      check_val({name, ".tag1"}, 32'(bus.out_tag1), 32'(et1));
      check_val({name, ".value2"}, bus.out_value2, ev2);
      check_val({name, ".tag2"}, 32'(bus.out_tag2), 32'(et2));
      check_val({name, ".cnt"}, 32'(bus.out_pending_cnt), 32'(ecnt));
   endtask

   task automatic check_model(input string name);
      logic [31:0] v1, v2;
      logic [3:0]  t1, t2;
      model_read(bus.in_rs1, v1, t1);
      model_read(bus.in_rs2, v2, t2);
      checkOutput(name, v1, t1, v2, t2, model_count());
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One cycle of the given operation; the model follows the same edge.
   task automatic op_cycle(input logic [4:0] rr, input logic [3:0] rt, input logic [4:0] cr,
                           input logic [3:0] ct, input logic [31:0] cv, input logic mb,
                           input logic [4:0] rs1, input logic [4:0] rs2);
      next_cycle();
      applyStimulus(rr, rt, cr, ct, cv, mb, rs1, rs2);
      @(negedge clk);
      model_edge();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [4:0] rr, cr;
      logic [3:0] rt, ct;
      vec_t v;

      vecs[0]  = '{5'd5, 4'd3, 5'd0, 4'd0, 32'h0, 1'b0, 5'd5, 5'd0, 32'h0, 4'd3, 32'h0, 4'd0, 6'd1};
      vecs[1]  = '{5'd0, 4'd0, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 4'd0, 32'h0, 4'd0, 6'd0};
      vecs[2]  = '{5'd7, 4'd2, 5'd0, 4'd0, 32'h0, 1'b0, 5'd7, 5'd5, 32'h0, 4'd2, 32'hDEADBEEF, 4'd0, 6'd1};
      vecs[3]  = '{5'd7, 4'd6, 5'd0, 4'd0, 32'h0, 1'b0, 5'd7, 5'd0, 32'h0, 4'd6, 32'h0, 4'd0, 6'd1};
      vecs[4]  = '{5'd0, 4'd0, 5'd7, 4'd2, 32'h11, 1'b0, 5'd7, 5'd0, 32'h11, 4'd6, 32'h0, 4'd0, 6'd1};
      vecs[5]  = '{5'd9, 4'd4, 5'd9, 4'd1, 32'h22, 1'b0, 5'd9, 5'd7, 32'h22, 4'd4, 32'h11, 4'd6, 6'd2};
      vecs[6]  = '{5'd1, 4'd5, 5'd0, 4'd0, 32'h0, 1'b0, 5'd1, 5'd9, 32'h0, 4'd5, 32'h22, 4'd4, 6'd3};
      vecs[7]  = '{5'd2, 4'd6, 5'd0, 4'd0, 32'h0, 1'b0, 5'd2, 5'd1, 32'h0, 4'd6, 32'h0, 4'd5, 6'd4};
      vecs[8]  = '{5'd3, 4'd7, 5'd4, 4'd0, 32'h33, 1'b1, 5'd4, 5'd3, 32'h33, 4'd0, 32'h0, 4'd0, 6'd0};
      vecs[9]  = '{5'd0, 4'd9, 5'd0, 4'd0, 32'h55, 1'b0, 5'd0, 5'd9, 32'h0, 4'd0, 32'h22, 4'd0, 6'd0};
      vecs[10] = '{5'd6, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd6, 5'd7, 32'h0, 4'd0, 32'h11, 4'd0, 6'd0};
      vecs[11] = '{5'd0, 4'd0, 5'd7, 4'd0, 32'h66, 1'b0, 5'd7, 5'd4, 32'h66, 4'd0, 32'h33, 4'd0, 6'd0};
      vecs[12] = '{5'd12, 4'd15, 5'd0, 4'd0, 32'h0, 1'b0, 5'd12, 5'd0, 32'h0, 4'd15, 32'h0, 4'd0, 6'd1};
      vecs[13] = '{5'd12, 4'd2, 5'd12, 4'd15, 32'h77, 1'b0, 5'd12, 5'd5, 32'h77, 4'd2, 32'hDEADBEEF, 4'd0, 6'd1};

      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 31);
      model_reset();
      #12;
      checkOutput("reset", 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
      rst = 1'b1;

      $display("[TB] directed vectors");
      for (int i = 0; i < 14; i++) begin
         v = vecs[i];
         op_cycle(v.rr, v.rt, v.cr, v.ct, v.cv, v.mb, 5'd0, 5'd0);
         next_cycle();
         applyStimulus(0, 0, 0, 0, 0, 0, v.rs1, v.rs2);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), v.ev1, v.et1, v.ev2, v.et2, v.ecnt);
      end

      // x12 still holds tag 2 from the vectors, so the pending count starts at 1 here.
      $display("[TB] commit bypass");
      op_cycle(5'd10, 4'd8, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      next_cycle();
      applyStimulus(5'd0, 4'd0, 5'd10, 4'd8, 32'h44, 1'b0, 5'd0, 5'd10);
      @(negedge clk);
`ifdef REGFILE_BYPASS_EN
      checkOutput("bypass.same", 32'h0, 4'd0, 32'h44, 4'd0, 6'd2);
`else
      checkOutput("bypass.same", 32'h0, 4'd0, 32'h0, 4'd8, 6'd2);
`endif
      model_edge();
      op_cycle(5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 5'd10);
      checkOutput("bypass.next", 32'h0, 4'd0, 32'h44, 4'd0, 6'd1);

      $display("[TB] fill every register");
      for (int r = 1; r < 32; r++)
         op_cycle(5'(r), 4'((r % 15) + 1), 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      op_cycle(5'd3, 4'd5, 5'd0, 4'd0, 32'h0, 1'b0, 5'd3, 5'd31);
      check_val("fill.cnt", 32'(bus.out_pending_cnt), 32'd31);
      op_cycle(5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd3, 5'd31);
      checkOutput("fill.overwrite", 32'h0, 4'd5, 32'h0, 4'd2, 6'd31);
      op_cycle(5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b1, 5'd0, 5'd0);
      op_cycle(5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd3, 5'd31);
      checkOutput("fill.flush", 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         rr = 5'($urandom_range(0, 7));
         rt = 4'($urandom_range(0, 15));
         cr = 5'($urandom_range(0, 7));
         ct = ($urandom_range(0, 1) == 1) ? m_tag[cr] : 4'($urandom_range(0, 15));
         next_cycle();
         applyStimulus(rr, rt, cr, ct, $urandom, ($urandom_range(0, 15) == 0),
                       5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
         @(negedge clk);
         check_model($sformatf("rand%0d", i));
         model_edge();
      end

      $display("[TB] asynchronous reset mid-run");
      op_cycle(5'd5, 4'd3, 5'd0, 4'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      next_cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
      @(negedge clk);
      check_model("prereset");
      #1 rst = 1'b0;
      #1;
      model_reset();
      checkOutput("midreset", 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);
      #1 rst = 1'b1;
      op_cycle(5'd0, 4'd0, 5'd0, 4'd0, 32'h0, 1'b0, 5'd5, 5'd7);
      checkOutput("postreset", 32'h0, 4'd0, 32'h0, 4'd0, 6'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
